// File: rtl/aes_sbox_pkg.sv
// Shared types and helpers for the AES SubBytes sequencer: FSM state codes, state sizes,
// byte-slice helper and FIPS-197 reference S-box points.
package aes_sbox_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_NBYTES  = 16;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam logic [7:0] FIPS_SBOX_00 = 8'h63;
    localparam logic [7:0] FIPS_SBOX_01 = 8'h7C;
    localparam logic [7:0] FIPS_SBOX_53 = 8'hED;

    // Byte 0 is the most significant byte of the state.
    function automatic logic [7:0] aes_byte(input logic [AES_STATE_W-1:0] st, input int idx);
        return st[AES_STATE_W-1-8*idx -: 8];
    endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One composite-field AES S-box: isomorphic map, GF(2^4) inversion, inverse map, affine.
// With SBOX_PIPE_EN defined the mapped nibble pair is registered (one cycle latency).
module aes_sbox_lane (
`ifdef SBOX_PIPE_EN
    input  logic       clk,
    input  logic       rst,
`endif
    input  logic [7:0] din,
    output logic [7:0] dout
);

    // Column i is the image of AES basis bit i; GF(16) = x^4+x+1, GF(256) = y^2+y+LAMBDA.
    localparam logic [63:0] ISO_COLS = {8'hEC, 8'h3F, 8'hD7, 8'h37, 8'h4A, 8'h40, 8'h23, 8'h01};
    localparam logic [63:0] INV_COLS = {8'h6B, 8'h04, 8'h5F, 8'hF2, 8'h50, 8'hE0, 8'h5C, 8'h01};
    localparam logic [3:0]  LAMBDA   = 4'hC;

    function automatic logic [7:0] lin_map(input logic [7:0] q, input logic [63:0] cols);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            if (q[i]) r = r ^ cols[8*i +: 8];
        return r;
    endfunction

    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        logic [3:0] s;
        r = '0;
        s = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r = r ^ s;
            s = {s[2:0], 1'b0} ^ (s[3] ? 4'b0011 : 4'b0000);
        end
        return r;
    endfunction

    // a^14 == a^-1 in GF(16); zero maps to zero.
    function automatic logic [3:0] gf4_inv(input logic [3:0] a);
        logic [3:0] a2, a4, a8;
        a2 = gf4_mul(a, a);
        a4 = gf4_mul(a2, a2);
        a8 = gf4_mul(a4, a4);
        return gf4_mul(gf4_mul(a2, a4), a8);
    endfunction

    logic [7:0] mapped;
    logic [7:0] mapped_q;
    logic [3:0] ah, al, d, di;
    logic [7:0] inv8;

    assign mapped = lin_map(din, ISO_COLS);

`ifdef SBOX_PIPE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mapped_q <= '0;
        else     mapped_q <= mapped;
    end
`else
    assign mapped_q = mapped;
`endif

    always_comb begin
        ah   = mapped_q[7:4];
        al   = mapped_q[3:0];
        d    = gf4_mul(gf4_mul(ah, ah), LAMBDA) ^ gf4_mul(ah, al) ^ gf4_mul(al, al);
        di   = gf4_inv(d);
        inv8 = lin_map({gf4_mul(ah, di), gf4_mul(ah ^ al, di)}, INV_COLS);
        dout = inv8 ^ {inv8[6:0], inv8[7]} ^ {inv8[5:0], inv8[7:6]}
                    ^ {inv8[4:0], inv8[7:5]} ^ {inv8[3:0], inv8[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/sbox_subbytes_seq.sv
// AES SubBytes sequencer: streams a 128-bit state LANES bytes/cycle through S-box lanes,
// result after 16/LANES cycles (+1 with SBOX_PIPE_EN); holds result until out_ready.
module sbox_subbytes_seq
    import aes_sbox_pkg::*;
#(
    parameter int LANES = 1,
    parameter int XLEN  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   busy
);

    localparam int NGROUP = AES_NBYTES / LANES;
    localparam int CNT_W  = (NGROUP > 1) ? $clog2(NGROUP) : 1;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [AES_STATE_W-1:0] work;
    logic [AES_STATE_W-1:0] result;
    logic                   last_grp;
    logic [XLEN-1:0]        lane_in  [LANES];
    logic [XLEN-1:0]        lane_out [LANES];
    logic                   wr_en;
    logic [CNT_W-1:0]       wr_grp;

    assign last_grp = (cnt == CNT_W'(NGROUP - 1));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_in[l] = aes_byte(work, int'(cnt) * LANES + l);
        aes_sbox_lane u_lane (
`ifdef SBOX_PIPE_EN
            .clk  (clk),
            .rst  (rst),
`endif
            .din  (lane_in[l]),
            .dout (lane_out[l])
        );
    end

    // With the lane pipeline, results land one cycle after their group was fed.
`ifdef SBOX_PIPE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en  <= 1'b0;
            wr_grp <= '0;
        end else begin
            wr_en  <= (state == ST_RUN);
            wr_grp <= cnt;
        end
    end
`else
    assign wr_en  = (state == ST_RUN);
    assign wr_grp = cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            work  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    work  <= in_state;
                    cnt   <= '0;
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (last_grp) begin
`ifdef SBOX_PIPE_EN
                        state <= ST_DRAIN;
`else
                        state <= ST_DONE;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DRAIN: state <= ST_DONE;
                ST_DONE:  if (out_ready) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
        end else if (wr_en) begin
            for (int l = 0; l < LANES; l++)
                result[AES_STATE_W-1-8*(int'(wr_grp)*LANES+l) -: 8] <= lane_out[l];
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign out_state = result;

endmodule

// File: tb/tb_sbox_subbytes_seq.sv
// Bench for sbox_subbytes_seq: directed and random states checked against a GF(2^8) S-box model.
module tb_sbox_subbytes_seq;
    import aes_sbox_pkg::*;

`ifdef SBOX_PIPE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    localparam logic [127:0] KAT_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] KAT_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, out_ready;
    logic [127:0] in_state;
    logic         in_ready, out_valid, busy;
    logic [127:0] out_state;
    logic         v2, r2;
    logic [127:0] st2;
    logic         rdy4, val4, busy4, rdy16, val16, busy16;
    logic [127:0] o4, o16;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb [256];

    always #5 clk = ~clk;

    sbox_subbytes_seq #(.LANES(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .busy(busy));
    sbox_subbytes_seq #(.LANES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy4), .in_state(st2),
        .out_valid(val4), .out_ready(r2), .out_state(o4), .busy(busy4));
    sbox_subbytes_seq #(.LANES(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy16), .in_state(st2),
        .out_valid(val16), .out_ready(r2), .out_state(o16), .busy(busy16));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
        end
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = '0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb[x] = s;
        end
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sb[s[127-8*i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic send_and_check(input logic [127:0] st, input string tag);
        int lat;
        for (int k = 0; k < 50 && !in_ready; k++) step();
        in_valid = 1'b1;
        in_state = st;
        step();
        in_valid = 1'b0;
        in_state = rand128();
        wait_valid(lat);
        chk($sformatf("%s_lat", tag), 128'(lat), 128'(16 + PIPE));
        chk($sformatf("%s_dat", tag), out_state, ref_sub(st));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk($sformatf("%s_idle", tag), 128'(in_ready), 128'(1));
    endtask

    initial begin
        logic [127:0] a, b;
        int lat, lat4, lat16;
        logic seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
        v2 = 1'b0; r2 = 1'b0; st2 = '0;
        build_sbox();
        step(); step();
        chk("rst_in_ready",  128'(in_ready),  128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy",      128'(busy),      128'(0));
        chk("rst_out_state", out_state,       128'(0));
        rst = 1'b0;
        step();

        // Wider lane counts on the known-answer vector
        v2 = 1'b1; st2 = KAT_IN;
        step();
        v2 = 1'b0;
        lat4 = -1; lat16 = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (val4  && lat4  < 0) lat4  = k;
            if (val16 && lat16 < 0) lat16 = k;
            if (lat4 >= 0 && lat16 >= 0) break;
        end
        chk("l4_lat",  128'(lat4),  128'(4 + PIPE));
        chk("l16_lat", 128'(lat16), 128'(1 + PIPE));
        chk("l4_dat",  o4,  KAT_OUT);
        chk("l16_dat", o16, KAT_OUT);
        r2 = 1'b1;
        step();
        r2 = 1'b0;
        chk("l4_idle",  128'(rdy4),  128'(1));
        chk("l16_idle", 128'(rdy16), 128'(1));

        // Known answer, all-zero and all-0x53 states on the single-lane build
        send_and_check(KAT_IN, "kat");
        chk("kat_model", ref_sub(KAT_IN), KAT_OUT);
        send_and_check('0, "zero");
        send_and_check({16{8'h53}}, "all53");

        // Backpressure: result and handshake signals hold while out_ready is low
        a = rand128();
        in_valid = 1'b1; in_state = a;
        step();
        in_valid = 1'b0;
        wait_valid(lat);
        chk("bp_lat", 128'(lat), 128'(16 + PIPE));
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("bp_dat%0d", k), out_state, ref_sub(a));
            chk($sformatf("bp_flags%0d", k), {125'd0, in_ready, busy, out_valid}, 128'b011);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release", {125'd0, in_ready, busy, out_valid}, 128'b100);

        // in_valid held with new data while busy; second state waits its turn
        a = rand128();
        b = rand128();
        in_valid = 1'b1; in_state = a;
        step();
        in_state = b;
        wait_valid(lat);
        chk("hold_lat_a", 128'(lat), 128'(16 + PIPE));
        chk("hold_dat_a", out_state, ref_sub(a));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("hold_gap", {126'd0, in_ready, busy}, 128'b10);
        step();
        in_valid = 1'b0;
        chk("hold_acc_b", 128'(busy), 128'(1));
        wait_valid(lat);
        chk("hold_lat_b", 128'(lat), 128'(16 + PIPE));
        chk("hold_dat_b", out_state, ref_sub(b));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset in the middle of a pass
        in_valid = 1'b1; in_state = rand128();
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) step();
        rst = 1'b1;
        #1;
        chk("abort_flags", {125'd0, in_ready, busy, out_valid}, 128'b100);
        chk("abort_state", out_state, 128'(0));
        step();
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chk("abort_nopulse", 128'(seen), 128'(0));
        send_and_check(rand128(), "post_abort");

        for (int n = 0; n < 4; n++) send_and_check(rand128(), $sformatf("rnd%0d", n));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
